// File: rtl/page_rank_if.sv
// AXI4 master (64-bit words on a 512-bit bus) and SoftReg bundle
// for the page_rank accelerator.
interface page_rank_if;
  logic [15:0]  arid_m;
  logic [63:0]  araddr_m;
  logic [7:0]   arlen_m;
  logic [2:0]   arsize_m;
  logic         arvalid_m;
  logic         arready_m;
  logic [15:0]  rid_m;
  logic [511:0] rdata_m;
  logic [1:0]   rresp_m;
  logic         rlast_m;
  logic         rvalid_m;
  logic         rready_m;
  logic [15:0]  awid_m;
  logic [63:0]  awaddr_m;
  logic [7:0]   awlen_m;
  logic [2:0]   awsize_m;
  logic         awvalid_m;
  logic         awready_m;
  logic [15:0]  wid_m;
  logic [511:0] wdata_m;
  logic [63:0]  wstrb_m;
  logic         wlast_m;
  logic         wvalid_m;
  logic         wready_m;
  logic [15:0]  bid_m;
  logic [1:0]   bresp_m;
  logic         bvalid_m;
  logic         bready_m;
  logic         softreg_req_valid;
  logic         softreg_req_isWrite;
  logic [31:0]  softreg_req_addr;
  logic [63:0]  softreg_req_data;
  logic         softreg_resp_valid;
  logic [63:0]  softreg_resp_data;

  modport master (
    output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
    input  arready_m,
    input  rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
    output rready_m,
    output awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
    input  awready_m,
    output wid_m, wdata_m, wstrb_m, wlast_m, wvalid_m,
    input  wready_m,
    input  bid_m, bresp_m, bvalid_m,
    output bready_m,
    input  softreg_req_valid, softreg_req_isWrite,
    input  softreg_req_addr, softreg_req_data,
    output softreg_resp_valid, softreg_resp_data
  );

  modport slave (
    input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
    output arready_m,
    output rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
    input  rready_m,
    input  awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
    output awready_m,
    input  wid_m, wdata_m, wstrb_m, wlast_m, wvalid_m,
    output wready_m,
    output bid_m, bresp_m, bvalid_m,
    input  bready_m,
    output softreg_req_valid, softreg_req_isWrite,
    output softreg_req_addr, softreg_req_data,
    input  softreg_resp_valid, softreg_resp_data
  );
endinterface

// File: rtl/page_rank.sv
// Pull-style fixed-point PageRank over an in-edge CSR graph.
// Optional PAGERANK_PERF_CNT_EN: SoftReg 0x40 reads start-to-done cycles.
module page_rank #(
  parameter int unsigned ITERS     = 4,
  parameter int unsigned FRAC_BITS = 16,
  parameter logic [63:0] DAMP      = 64'd55706,
  parameter logic [15:0] AXI_ID    = 16'd0
) (
  input logic clk,
  input logic rst,
  page_rank_if.master m
);
  localparam logic [63:0] ONE  = 64'd1 << FRAC_BITS;
  localparam logic [63:0] BASE = ONE - DAMP;
  localparam logic [31:0] LAST_IT = 32'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VERT, S_SRC, S_OLD,
    S_DEG, S_DIV, S_WRITE, S_DONE
  } state_t;

  state_t      r_state;
  logic [63:0] r_nvert, r_nedge, r_vaddr, r_ieaddr;
  logic [63:0] r_wa0, r_wa1, r_total;
  logic        r_done, r_pend, r_iss;
  logic [63:0] r_v, r_start, r_end, r_i, r_u;
  logic [63:0] r_old, r_deg, r_sum, r_quo, r_rem;
  logic [5:0]  r_cnt;
  logic [31:0] r_iter;
  logic        r_arvalid, r_rready, r_awvalid;
  logic        r_wvalid, r_bready, r_resp_valid;
  logic [63:0] r_araddr, r_awaddr, r_wdata, r_resp_data;
`ifdef PAGERANK_PERF_CNT_EN
  logic [63:0] r_cyc;
`endif

  logic [63:0] w_rword, w_rd_data, w_prod, w_new;
  logic [63:0] w_oldbase, w_newbase, w_quo_nx, w_rem_nx;
  logic [64:0] w_rem_sh;
  logic        w_ge, w_rdone, w_sr_rd, w_sr_wr, w_start;
  logic        w_last_it, w_last_v;
  logic        w_unused;

  assign w_unused = ^{m.rid_m, m.rresp_m, m.rlast_m,
                      m.bid_m, m.bresp_m};

  assign w_rword = m.rdata_m[{r_araddr[5:3], 6'd0} +: 64];
  assign w_rdone = r_rready && m.rvalid_m;
  assign w_sr_rd = m.softreg_req_valid && !m.softreg_req_isWrite;
  assign w_sr_wr = m.softreg_req_valid && m.softreg_req_isWrite;
  assign w_start = w_sr_wr && (m.softreg_req_addr == 32'h30) &&
                   (r_state == S_IDLE || r_state == S_DONE);

  // restoring divider step: remainder shifted left by one dividend bit
  assign w_rem_sh = {r_rem, r_quo[63]};
  assign w_ge     = w_rem_sh >= {1'b0, r_deg};
  assign w_rem_nx = w_ge ? 64'(w_rem_sh - {1'b0, r_deg})
                         : w_rem_sh[63:0];
  assign w_quo_nx = {r_quo[62:0], w_ge};

  assign w_prod    = DAMP * r_sum;
  assign w_new     = BASE + (w_prod >> FRAC_BITS);
  assign w_last_it = r_iter == LAST_IT;
  assign w_last_v  = r_v == r_nvert - 64'd1;
  assign w_oldbase = r_iter[0] ? r_wa0 : r_wa1;
  assign w_newbase = r_iter[0] ? r_wa1 : r_wa0;

  always_comb begin
    w_rd_data = '0;
    case (m.softreg_req_addr)
      32'h00: w_rd_data = r_nvert;
      32'h08: w_rd_data = r_nedge;
      32'h10: w_rd_data = r_vaddr;
      32'h18: w_rd_data = r_ieaddr;
      32'h20: w_rd_data = r_wa0;
      32'h28: w_rd_data = r_wa1;
`ifdef PAGERANK_PERF_CNT_EN
      32'h40: w_rd_data = r_cyc;
`endif
      default: w_rd_data = '0;
    endcase
  end

  assign m.arid_m    = AXI_ID;
  assign m.araddr_m  = r_araddr;
  assign m.arlen_m   = 8'd0;
  assign m.arsize_m  = 3'd3;
  assign m.arvalid_m = r_arvalid;
  assign m.rready_m  = r_rready;
  assign m.awid_m    = AXI_ID;
  assign m.awaddr_m  = r_awaddr;
  assign m.awlen_m   = 8'd0;
  assign m.awsize_m  = 3'd3;
  assign m.awvalid_m = r_awvalid;
  assign m.wid_m     = AXI_ID;
  assign m.wdata_m   = {8{r_wdata}};
  assign m.wstrb_m   = 64'hFF << {r_awaddr[5:3], 3'd0};
  assign m.wlast_m   = 1'b1;
  assign m.wvalid_m  = r_wvalid;
  assign m.bready_m  = r_bready;
  assign m.softreg_resp_valid = r_resp_valid;
  assign m.softreg_resp_data  = r_resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_nvert <= '0; r_nedge <= '0;
      r_vaddr <= '0; r_ieaddr <= '0;
      r_wa0 <= '0; r_wa1 <= '0; r_total <= '0;
      r_done <= 1'b0; r_pend <= 1'b0; r_iss <= 1'b0;
      r_v <= '0; r_start <= '0; r_end <= '0;
      r_i <= '0; r_u <= '0; r_old <= '0; r_deg <= '0;
      r_sum <= '0; r_quo <= '0; r_rem <= '0;
      r_cnt <= '0; r_iter <= '0;
      r_arvalid <= 1'b0; r_rready <= 1'b0;
      r_awvalid <= 1'b0; r_wvalid <= 1'b0;
      r_bready <= 1'b0; r_resp_valid <= 1'b0;
      r_araddr <= '0; r_awaddr <= '0;
      r_wdata <= '0; r_resp_data <= '0;
`ifdef PAGERANK_PERF_CNT_EN
      r_cyc <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      if (w_sr_wr) begin
        case (m.softreg_req_addr)
          32'h00: r_nvert  <= m.softreg_req_data;
          32'h08: r_nedge  <= m.softreg_req_data;
          32'h10: r_vaddr  <= m.softreg_req_data;
          32'h18: r_ieaddr <= m.softreg_req_data;
          32'h20: r_wa0    <= m.softreg_req_data;
          32'h28: r_wa1    <= m.softreg_req_data;
          default: ;
        endcase
      end
      // DONE_ALL reads park in r_pend until the run completes
      if (w_sr_rd) begin
        if (m.softreg_req_addr == 32'h38) begin
          if (r_done) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= r_total;
          end else begin
            r_pend <= 1'b1;
          end
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_rd_data;
        end
      end else if (r_pend && r_done) begin
        r_pend       <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_data  <= r_total;
      end

      if (r_arvalid && m.arready_m) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_rdone) r_rready <= 1'b0;
      if (r_awvalid && m.awready_m) r_awvalid <= 1'b0;
      if (r_wvalid && m.wready_m) r_wvalid <= 1'b0;

      case (r_state)
        S_VERT: begin
          if (!r_iss) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_vaddr + {r_v[59:0], 4'd0};
            r_iss     <= 1'b1;
          end else if (w_rdone) begin
            r_iss   <= 1'b0;
            r_end   <= w_rword;
            r_i     <= r_start;
            r_state <= S_SRC;
          end
        end
        S_SRC: begin
          if (!r_iss) begin
            if (r_i >= r_end) begin
              r_state <= S_WRITE;
            end else if (r_i >= r_nedge) begin
              r_i <= r_i + 64'd1;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= r_ieaddr + {r_i[60:0], 3'd0};
              r_iss     <= 1'b1;
            end
          end else if (w_rdone) begin
            r_iss   <= 1'b0;
            r_u     <= w_rword;
            r_state <= S_OLD;
          end
        end
        S_OLD: begin
          if (!r_iss) begin
            if (r_iter == 32'd0) begin
              r_old   <= ONE;
              r_state <= S_DEG;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= w_oldbase + {r_u[60:0], 3'd0};
              r_iss     <= 1'b1;
            end
          end else if (w_rdone) begin
            r_iss   <= 1'b0;
            r_old   <= w_rword;
            r_state <= S_DEG;
          end
        end
        S_DEG: begin
          if (!r_iss) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_vaddr + {r_u[59:0], 4'd8};
            r_iss     <= 1'b1;
          end else if (w_rdone) begin
            r_iss <= 1'b0;
            if (w_rword == 64'd0) begin
              r_i     <= r_i + 64'd1;
              r_state <= S_SRC;
            end else begin
              r_deg   <= w_rword;
              r_quo   <= r_old;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_sum   <= r_sum + w_quo_nx;
            r_i     <= r_i + 64'd1;
            r_state <= S_SRC;
          end
        end
        S_WRITE: begin
          if (!r_iss) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_bready  <= 1'b1;
            r_awaddr  <= w_newbase + {r_v[60:0], 3'd0};
            r_wdata   <= w_new;
            r_iss     <= 1'b1;
          end else if (r_bready && m.bvalid_m) begin
            r_bready <= 1'b0;
            r_iss    <= 1'b0;
            r_sum    <= '0;
            r_start  <= r_end;
            if (w_last_it) r_total <= r_total + r_wdata;
            if (!w_last_v) begin
              r_v     <= r_v + 64'd1;
              r_state <= S_VERT;
            end else begin
              r_v     <= '0;
              r_start <= '0;
              if (w_last_it) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_iter  <= r_iter + 32'd1;
                r_state <= S_VERT;
              end
            end
          end
        end
        default: ;
      endcase

      if (w_start) begin
        r_done  <= r_nvert == 64'd0;
        r_total <= '0;
        r_v     <= '0;
        r_iter  <= '0;
        r_start <= '0;
        r_sum   <= '0;
        r_iss   <= 1'b0;
        r_state <= (r_nvert == 64'd0) ? S_DONE : S_VERT;
      end
`ifdef PAGERANK_PERF_CNT_EN
      if (w_start)
        r_cyc <= '0;
      else if (r_state != S_IDLE && r_state != S_DONE)
        r_cyc <= r_cyc + 64'd1;
`endif
    end
  end
endmodule

// File: tb/tb_page_rank.sv
// Directed bench for page_rank: AXI memory model with optional
// random stalls, SoftReg driver, table of graphs with known ranks.
module tb_page_rank;
  localparam logic [63:0] VA  = 64'h1000;
  localparam logic [63:0] IE  = 64'h2000;
  localparam logic [63:0] WA0 = 64'h3000;
  localparam logic [63:0] WA1 = 64'h4000;

  typedef struct packed {
    logic [31:0]       nv;
    logic [63:0]       ne;
    logic [3:0][63:0]  endi;
    logic [3:0][63:0]  deg;
    logic [3:0][63:0]  src;
    logic [3:0][63:0]  er;
    logic [63:0]       esum;
    logic              st;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  page_rank_if bus();
  page_rank dut (.clk(clk), .rst(rst), .m(bus));

  logic [63:0] mem [longint];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int last_b_cyc = -1;
  bit stall = 1'b0;
  vec_t tv [8];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.softreg_resp_valid) resp_cnt <= resp_cnt + 1;

  function automatic logic [63:0] rdmem(logic [63:0] a);
    longint k;
    k = longint'(a >> 3);
    return mem.exists(k) ? mem[k] : 64'h0;
  endfunction

  function automatic int dly();
    return stall ? int'($urandom_range(0, 5)) : 0;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // read slave: AR accept, optional stall, one R beat
  initial begin
    int rph, rdly, ln;
    logic [63:0] ra;
    rph = 0; rdly = 0; ln = 0; ra = '0;
    bus.arready_m = 0; bus.rvalid_m = 0; bus.rdata_m = '0;
    bus.rid_m = '0; bus.rresp_m = '0; bus.rlast_m = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.arready_m = 0; bus.rvalid_m = 0; rph = 0; rdly = 0;
      end else begin
        case (rph)
          0: if (bus.arvalid_m) begin
            if (rdly == 0) begin
              bus.arready_m = 1; ra = bus.araddr_m; rph = 1;
            end else rdly--;
          end
          1: begin bus.arready_m = 0; rdly = dly(); rph = 2; end
          2: if (rdly != 0) rdly--;
             else if (bus.rready_m) begin
               ln = int'(ra[5:3]);
               bus.rdata_m = {8{64'hA5A5_5A5A_DEAD_BEEF}};
               bus.rdata_m[64*ln +: 64] = rdmem(ra);
               bus.rvalid_m = 1; rph = 3;
             end
          default: begin bus.rvalid_m = 0; rdly = dly(); rph = 0; end
        endcase
      end
    end
  end

  // write slave: independent AW/W accept, then B
  initial begin
    int wph, adly, wdly, bdly, ln;
    bit ad, wd;
    logic [63:0] wa, wstb;
    logic [511:0] wdat;
    wph = 0; adly = 0; wdly = 0; bdly = 0; ln = 0;
    ad = 0; wd = 0; wa = '0; wstb = '0; wdat = '0;
    bus.awready_m = 0; bus.wready_m = 0; bus.bvalid_m = 0;
    bus.bid_m = '0; bus.bresp_m = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.awready_m = 0; bus.wready_m = 0;
        bus.bvalid_m = 0; wph = 0;
      end else begin
        case (wph)
          0: if (bus.awvalid_m && bus.wvalid_m) begin
            adly = dly(); wdly = dly(); ad = 0; wd = 0;
            wa = bus.awaddr_m; wph = 1;
          end
          1: begin
            bus.awready_m = 0; bus.wready_m = 0;
            if (!ad) begin
              if (adly == 0) begin bus.awready_m = 1; ad = 1; end
              else adly--;
            end
            if (!wd) begin
              if (wdly == 0) begin
                bus.wready_m = 1; wd = 1;
                wdat = bus.wdata_m; wstb = bus.wstrb_m;
              end else wdly--;
            end
            if (ad && wd && !bus.awready_m && !bus.wready_m) begin
              ln = int'(wa[5:3]);
              chk("wstrb", wstb, 64'hFF << (8*ln));
              mem[longint'(wa >> 3)] = wdat[64*ln +: 64];
              bdly = dly(); wph = 2;
            end
          end
          2: if (bdly != 0) bdly--;
             else if (bus.bready_m) begin
               bus.bvalid_m = 1; last_b_cyc = cyc; wph = 3;
             end
          default: begin bus.bvalid_m = 0; wph = 0; end
        endcase
      end
    end
  end

  task automatic sr_write(logic [31:0] a, logic [63:0] d);
    @(negedge clk);
    bus.softreg_req_valid = 1; bus.softreg_req_isWrite = 1;
    bus.softreg_req_addr = a; bus.softreg_req_data = d;
    @(negedge clk);
    bus.softreg_req_valid = 0; bus.softreg_req_isWrite = 0;
  endtask

  task automatic sr_read(logic [31:0] a, output logic [63:0] d,
                         output int c, output bit ok);
    d = '0; c = 0; ok = 0;
    @(negedge clk);
    bus.softreg_req_valid = 1; bus.softreg_req_isWrite = 0;
    bus.softreg_req_addr = a;
    @(negedge clk);
    bus.softreg_req_valid = 0;
    for (int k = 0; k < 40000; k++) begin
      if (bus.softreg_resp_valid) begin
        d = bus.softreg_resp_data; c = cyc; ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL sr_timeout addr %0h got none want resp", a);
    end
  endtask

  task automatic load_start(vec_t t);
    mem.delete();
    stall = t.st;
    for (int v = 0; v < 4; v++) begin
      mem[longint'(VA >> 3) + 2*v]     = t.endi[v];
      mem[longint'(VA >> 3) + 2*v + 1] = t.deg[v];
      mem[longint'(IE >> 3) + v]       = t.src[v];
      mem[longint'(WA0 >> 3) + v]      = 64'hBAD;
      mem[longint'(WA1 >> 3) + v]      = 64'hBAD;
    end
    sr_write(32'h00, 64'(t.nv));
    sr_write(32'h08, t.ne);
    sr_write(32'h10, VA);
    sr_write(32'h18, IE);
    sr_write(32'h20, WA0);
    sr_write(32'h28, WA1);
    last_b_cyc = -1;
    sr_write(32'h30, 64'h0);
  endtask

  task automatic finish_check(vec_t t, string nm, bit restart);
    logic [63:0] d;
    int c, rc0;
    bit ok;
    if (restart) begin
      repeat (200) @(negedge clk);
      sr_write(32'h30, 64'h0);
    end
    rc0 = resp_cnt;
    sr_read(32'h38, d, c, ok);
    chk({nm, "_sum"}, d, t.esum);
    for (int v = 0; v < int'(t.nv); v++)
      chk($sformatf("%s_rank%0d", nm, v),
          rdmem(WA1 + 64'(8*v)), t.er[v]);
    if (t.nv != 0 && ok)
      chk({nm, "_done_lat"}, 64'(c - last_b_cyc), 64'd2);
    repeat (4) @(negedge clk);
    chk({nm, "_resp_once"}, 64'(resp_cnt - rc0), 64'd1);
  endtask

  initial begin
    logic [63:0] d;
    int c;
    bit ok;
    bus.softreg_req_valid = 0; bus.softreg_req_isWrite = 0;
    bus.softreg_req_addr = '0; bus.softreg_req_data = '0;

    for (int k = 0; k < 8; k++) tv[k] = '0;
    // 2-vertex cycle: fixed point at 1.0
    tv[0].nv = 2; tv[0].ne = 2;
    tv[0].endi[0] = 1; tv[0].endi[1] = 2;
    tv[0].deg[0] = 1; tv[0].deg[1] = 1;
    tv[0].src[0] = 1; tv[0].src[1] = 0;
    tv[0].er[0] = 65536; tv[0].er[1] = 65536;
    tv[0].esum = 131072;
    // single isolated vertex
    tv[1].nv = 1; tv[1].ne = 0;
    tv[1].er[0] = 9830; tv[1].esum = 9830;
    // v1 <- v0, v1 is a sink
    tv[2].nv = 2; tv[2].ne = 1;
    tv[2].endi[0] = 0; tv[2].endi[1] = 1;
    tv[2].deg[0] = 1; tv[2].deg[1] = 0;
    tv[2].src[0] = 0;
    tv[2].er[0] = 9830; tv[2].er[1] = 18185;
    tv[2].esum = 28015;
    // 3-vertex star-ish graph, exercises divide by 2
    tv[3].nv = 3; tv[3].ne = 4;
    tv[3].endi[0] = 2; tv[3].endi[1] = 3; tv[3].endi[2] = 4;
    tv[3].deg[0] = 2; tv[3].deg[1] = 1; tv[3].deg[2] = 1;
    tv[3].src[0] = 1; tv[3].src[1] = 2;
    tv[3].src[2] = 0; tv[3].src[3] = 0;
    tv[3].er[0] = 79926; tv[3].er[1] = 58338; tv[3].er[2] = 58338;
    tv[3].esum = 196602;
    // 2-cycle with edge 1 beyond N_INEDGES
    tv[4] = tv[0]; tv[4].ne = 1;
    tv[4].er[0] = 18185; tv[4].er[1] = 9830; tv[4].esum = 28015;
    tv[5] = tv[3]; tv[5].st = 1;
    tv[6] = tv[0]; tv[6].st = 1;
    // N_VERT = 0
    tv[7].nv = 0; tv[7].esum = 0;

    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(bus.arvalid_m), 64'd0);
    chk("rst_awvalid", 64'(bus.awvalid_m), 64'd0);
    chk("rst_wvalid", 64'(bus.wvalid_m), 64'd0);
    chk("rst_rready", 64'(bus.rready_m), 64'd0);
    chk("rst_bready", 64'(bus.bready_m), 64'd0);
    chk("rst_resp", 64'(bus.softreg_resp_valid), 64'd0);
    #1 rst = 0;

    sr_write(32'h00, 64'd3);
    sr_read(32'h00, d, c, ok);
    chk("rd_nvert", d, 64'd3);
    sr_write(32'h18, 64'h2000);
    sr_read(32'h18, d, c, ok);
    chk("rd_ieaddr", d, 64'h2000);
    sr_read(32'h48, d, c, ok);
    chk("rd_unmapped", d, 64'd0);

    for (int k = 0; k < 8; k++) begin
      load_start(tv[k]);
      finish_check(tv[k], $sformatf("vec%0d", k), 1'b0);
    end

    load_start(tv[3]);
    finish_check(tv[3], "perf_run", 1'b0);
    sr_read(32'h40, d, c, ok);
`ifdef PAGERANK_PERF_CNT_EN
    chk("perf_nonzero", 64'(d != 0), 64'd1);
`else
    chk("perf_absent", d, 64'd0);
`endif

    load_start(tv[3]);
    repeat (150) @(negedge clk);
    for (int k = 0; k < 300 && !bus.arvalid_m; k++)
      @(negedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_arvalid", 64'(bus.arvalid_m), 64'd0);
    chk("midrst_awvalid", 64'(bus.awvalid_m), 64'd0);
    chk("midrst_wvalid", 64'(bus.wvalid_m), 64'd0);
    chk("midrst_rready", 64'(bus.rready_m), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    load_start(tv[3]);
    finish_check(tv[3], "rerun", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
